mmf_sched: RTL

- Time-multiplexes one shared mmf update datapath across NUM_CH independent channels (neuron contexts).
- Each channel presents a request plus an input current. The scheduler picks one channel round-robin, drives the datapath with that channel's current and stored state, waits the datapath latency, then writes the result back.
- Also reports per-channel completion and a threshold-crossing spike.
- Sits between the tt_um top-level pin mapping and a single mmf datapath instance.

---
 rtl/mmf_sched_pkg.sv | 27 ++
 rtl/mmf_sched_if.sv | 23 ++
 rtl/mmf_rr_arbiter.sv | 46 ++++
 rtl/mmf_sched.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mmf_sched_pkg.sv
// Shared types and sizing helpers for the mmf_sched channel scheduler.
// Holds the FSM state encoding plus the index/counter width rules used by the top.
package mmf_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITEBACK
    } sched_state_e;

    // Channel index needs at least one bit even for tiny channel counts.
    function automatic int idx_width(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

    // The wait counter holds DP_LAT-1 at most.
    function automatic int cnt_width(input int dp_lat);
        return (dp_lat <= 2) ? 1 : $clog2(dp_lat);
    endfunction

    localparam int NUM_CH_DEF = 4;
    localparam int DP_LAT_DEF = 1;
    localparam int CH_IDX_W   = idx_width(NUM_CH_DEF);
    localparam int CNT_W      = cnt_width(DP_LAT_DEF);

endpackage

// File: rtl/mmf_sched_if.sv
// Requester-side bundle of the scheduler: per-channel requests and currents in,
// grants, spikes, stored contexts and busy out.
interface mmf_sched_if #(
    parameter int NUM_CH = 4,
    parameter int W      = 8
);
    logic [NUM_CH-1:0]   req;
    logic [NUM_CH*W-1:0] current;
    logic [NUM_CH-1:0]   grant;
    logic [NUM_CH-1:0]   spike;
    logic [NUM_CH*W-1:0] state_out;
    logic                busy;

    modport master (
        output req, current,
        input  grant, spike, state_out, busy
    );

    modport slave (
        input  req, current,
        output grant, spike, state_out, busy
    );
endinterface

// File: rtl/mmf_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// With MMF_SCHED_PRIO_EN defined, req[0] overrides the rotation and flags prio_win.
module mmf_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              found,
    output logic [IDX_W-1:0]  sel,
    output logic              prio_win
);

    localparam logic [IDX_W:0] NUM_CH_X = (IDX_W+1)'(NUM_CH);

    logic [IDX_W-1:0]  cand [NUM_CH];
    logic [NUM_CH-1:0] cand_req;

    // cand[gi] is the channel sitting gi places after the pointer.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
        logic [IDX_W:0] sum;
        assign sum          = {1'b0, ptr} + (IDX_W+1)'(gi);
        assign cand[gi]     = (sum >= NUM_CH_X) ? IDX_W'(sum - NUM_CH_X) : sum[IDX_W-1:0];
        assign cand_req[gi] = req[cand[gi]];
    end

    always_comb begin
        found    = 1'b0;
        sel      = '0;
        prio_win = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                found = 1'b1;
                sel   = cand[k];
            end
        end
`ifdef MMF_SCHED_PRIO_EN
        if (req[0]) begin
            found    = 1'b1;
            sel      = '0;
            prio_win = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/mmf_sched.sv
// Time-multiplexes one mmf update datapath across NUM_CH channel contexts.
// Optional channel-0 priority is enabled by defining MMF_SCHED_PRIO_EN.
module mmf_sched
    import mmf_sched_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int W        = 8,
    parameter int DP_LAT   = 1,
    parameter int SPIKE_TH = 200
) (
    input  logic          clk,
    input  logic          reset,
    mmf_sched_if.slave    bus,
    output logic          dp_start,
    output logic [W-1:0]  dp_current,
    output logic [W-1:0]  dp_state,
    input  logic [W-1:0]  dp_result
);

    localparam int IDX_W = idx_width(NUM_CH);
    localparam int CTR_W = cnt_width(DP_LAT);

    sched_state_e      state_q, state_d;
    logic [IDX_W-1:0]  ch_q, ch_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CTR_W-1:0]  cnt_q, cnt_d;
    logic              prio_q, prio_d;
    logic              dp_start_q, dp_start_d;
    logic [W-1:0]      dp_cur_q, dp_cur_d;
    logic [W-1:0]      dp_st_q, dp_st_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [NUM_CH-1:0] spike_q, spike_d;
    logic              busy_q, busy_d;
    logic [W-1:0]      ctx_q [NUM_CH];
    logic [W-1:0]      ctx_d [NUM_CH];

    logic              arb_found;
    logic [IDX_W-1:0]  arb_sel;
    logic              arb_prio;

    mmf_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req      (bus.req),
        .ptr      (ptr_q),
        .found    (arb_found),
        .sel      (arb_sel),
        .prio_win (arb_prio)
    );

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        prio_d     = prio_q;
        dp_start_d = 1'b0;
        dp_cur_d   = dp_cur_q;
        dp_st_d    = dp_st_q;
        grant_d    = '0;
        spike_d    = '0;
        ctx_d      = ctx_q;
        unique case (state_q)
            ST_IDLE: begin
                // Operands are captured here and held until the write-back finishes.
                if (arb_found) begin
                    ch_d       = arb_sel;
                    prio_d     = arb_prio;
                    dp_cur_d   = bus.current[int'(arb_sel)*W +: W];
                    dp_st_d    = ctx_q[arb_sel];
                    dp_start_d = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CTR_W'(DP_LAT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    ctx_d[ch_q]   = dp_result;
                    grant_d[ch_q] = 1'b1;
                    spike_d[ch_q] = (dp_result >= W'(SPIKE_TH));
                    if (!prio_q) begin
                        ptr_d = (ch_q == IDX_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
                    end
                    state_d = ST_WRITEBACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WRITEBACK: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            prio_q     <= 1'b0;
            dp_start_q <= 1'b0;
            dp_cur_q   <= '0;
            dp_st_q    <= '0;
            grant_q    <= '0;
            spike_q    <= '0;
            busy_q     <= 1'b0;
            ctx_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            prio_q     <= prio_d;
            dp_start_q <= dp_start_d;
            dp_cur_q   <= dp_cur_d;
            dp_st_q    <= dp_st_d;
            grant_q    <= grant_d;
            spike_q    <= spike_d;
            busy_q     <= busy_d;
            ctx_q      <= ctx_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_state_out
        assign bus.state_out[gi*W +: W] = ctx_q[gi];
    end

    assign bus.grant  = grant_q;
    assign bus.spike  = spike_q;
    assign bus.busy   = busy_q;
    assign dp_start   = dp_start_q;
    assign dp_current = dp_cur_q;
    assign dp_state   = dp_st_q;

endmodule
